// File: rtl/packet_tagger.sv
`default_nettype none
// ============================================================================
//  Module      : packet_tagger
//  Description : Ingress stage of the packet filter. Stamps each packet with
//                a wrapping reorder tag and forks every beat to the circular
//                buffer and to one idle filter core chosen round-robin.
//                Over-long packets are cut at MAX_TDATA_PER_PACKET beats and
//                their remainder is drained.
//  Revision    : 1.0 - initial release
// ============================================================================
module packet_tagger #(
    parameter int TAG_WIDTH            = 6,
    parameter int CIRCULAR_BUFFER_SIZE = 50,
    parameter int DATA_WIDTH           = 64,
    parameter int N_CORES              = 4,
    parameter int MAX_TDATA_PER_PACKET = 375,
    localparam int SEL_W               = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_TDATA,
    input  logic                  s_TLAST,
    input  logic                  s_TVALID,
    output logic                  s_TREADY,
    output logic [DATA_WIDTH-1:0] buffer_TDATA,
    output logic                  buffer_TLAST,
    output logic                  buffer_TVALID,
    input  logic                  buffer_TREADY,
    output logic [TAG_WIDTH-1:0]  reorder_tag,
    output logic [DATA_WIDTH-1:0] core_TDATA,
    output logic                  core_TLAST,
    output logic [N_CORES-1:0]    core_TVALID,
    input  logic [N_CORES-1:0]    core_TREADY,
    input  logic [N_CORES-1:0]    core_idle,
    output logic [SEL_W-1:0]      core_sel
);

    localparam int CNT_W = $clog2(MAX_TDATA_PER_PACKET + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic [SEL_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;

    logic                 found;
    logic [SEL_W-1:0]     pick;
    logic [SEL_W:0]       cand;
    logic [SEL_W:0]       sel_inc;
    logic                 x_last;
    logic                 xfer;

    // Round-robin search: first idle core starting at rr_ptr, wrapping mod N_CORES
    always_comb begin
        found = 1'b0;
        pick  = sel_q;
        cand  = '0;
        for (int i = 0; i < N_CORES; i++) begin
            cand = {1'b0, rr_ptr_q} + (SEL_W+1)'(i);
            if (cand >= (SEL_W+1)'(N_CORES)) begin
                cand = cand - (SEL_W+1)'(N_CORES);
            end
            if (!found && core_idle[cand[SEL_W-1:0]]) begin
                found = 1'b1;
                pick  = cand[SEL_W-1:0];
            end
        end
    end

    // Beats past the limit are cut: the limit beat carries TLAST downstream
    assign x_last  = s_TLAST || (beat_cnt_q == CNT_W'(MAX_TDATA_PER_PACKET - 1));
    assign sel_inc = {1'b0, sel_q} + (SEL_W+1)'(1);

    assign buffer_TDATA = s_TDATA;
    assign core_TDATA   = s_TDATA;
    assign buffer_TLAST = x_last;
    assign core_TLAST   = x_last;
    assign reorder_tag  = tag_q;
    assign core_sel     = sel_q;

    // Next-state and fork handshake logic
    always_comb begin
        state_d       = state_q;
        tag_d         = tag_q;
        rr_ptr_d      = rr_ptr_q;
        sel_d         = sel_q;
        beat_cnt_d    = beat_cnt_q;
        s_TREADY      = 1'b0;
        buffer_TVALID = 1'b0;
        core_TVALID   = '0;
        xfer          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (s_TVALID && found) begin
                    sel_d   = pick;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                s_TREADY             = buffer_TREADY && core_TREADY[sel_q];
                buffer_TVALID        = s_TVALID && core_TREADY[sel_q];
                core_TVALID[sel_q]   = s_TVALID && buffer_TREADY;
                xfer                 = s_TVALID && buffer_TREADY && core_TREADY[sel_q];
                if (xfer) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (x_last) begin
                        tag_d      = (tag_q == TAG_WIDTH'(CIRCULAR_BUFFER_SIZE - 1)) ?
                                     '0 : tag_q + TAG_WIDTH'(1);
                        rr_ptr_d   = (sel_inc >= (SEL_W+1)'(N_CORES)) ? '0 : sel_inc[SEL_W-1:0];
                        beat_cnt_d = '0;
                        state_d    = s_TLAST ? S_IDLE : S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                s_TREADY = 1'b1;
                if (s_TVALID && s_TLAST) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and packet-context registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tag_q      <= '0;
            rr_ptr_q   <= '0;
            sel_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tag_q      <= tag_d;
            rr_ptr_q   <= rr_ptr_d;
            sel_q      <= sel_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_packet_tagger.sv
`default_nettype none
// ============================================================================
//  Module      : tb_packet_tagger
//  Description : Directed self-checking bench for packet_tagger. A second
//                instance with an 8-beat limit covers truncation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_packet_tagger;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] s_TDATA;
    logic        s_TLAST, s_TVALID;
    logic        buffer_TREADY;
    logic [3:0]  core_TREADY, core_idle;

    logic        s_TREADY, buffer_TLAST, buffer_TVALID, core_TLAST;
    logic [63:0] buffer_TDATA, core_TDATA;
    logic [5:0]  reorder_tag;
    logic [3:0]  core_TVALID;
    logic [1:0]  core_sel;

    logic        m_s_TREADY, m_buffer_TLAST, m_buffer_TVALID, m_core_TLAST;
    logic [63:0] m_buffer_TDATA, m_core_TDATA;
    logic [5:0]  m_reorder_tag;
    logic [3:0]  m_core_TVALID;
    logic [1:0]  m_core_sel;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] d;
        logic        l;
        logic [5:0]  t;
        logic [1:0]  s;
    } beat_t;

    beat_t bq[$], cq[$], mbq[$], mcq[$];

    always #5 clk = ~clk;

    packet_tagger dut (
        .clk(clk), .rst(rst),
        .s_TDATA(s_TDATA), .s_TLAST(s_TLAST), .s_TVALID(s_TVALID), .s_TREADY(s_TREADY),
        .buffer_TDATA(buffer_TDATA), .buffer_TLAST(buffer_TLAST),
        .buffer_TVALID(buffer_TVALID), .buffer_TREADY(buffer_TREADY),
        .reorder_tag(reorder_tag),
        .core_TDATA(core_TDATA), .core_TLAST(core_TLAST),
        .core_TVALID(core_TVALID), .core_TREADY(core_TREADY),
        .core_idle(core_idle), .core_sel(core_sel)
    );

    packet_tagger #(.MAX_TDATA_PER_PACKET(8)) dut_m (
        .clk(clk), .rst(rst),
        .s_TDATA(s_TDATA), .s_TLAST(s_TLAST), .s_TVALID(s_TVALID), .s_TREADY(m_s_TREADY),
        .buffer_TDATA(m_buffer_TDATA), .buffer_TLAST(m_buffer_TLAST),
        .buffer_TVALID(m_buffer_TVALID), .buffer_TREADY(buffer_TREADY),
        .reorder_tag(m_reorder_tag),
        .core_TDATA(m_core_TDATA), .core_TLAST(m_core_TLAST),
        .core_TVALID(m_core_TVALID), .core_TREADY(core_TREADY),
        .core_idle(core_idle), .core_sel(m_core_sel)
    );

    // Record every beat that completes a handshake on each sink
    always @(posedge clk) begin
        if (buffer_TVALID && buffer_TREADY)
            bq.push_back('{buffer_TDATA, buffer_TLAST, reorder_tag, core_sel});
        if (|(core_TVALID & core_TREADY))
            cq.push_back('{core_TDATA, core_TLAST, reorder_tag, core_sel});
        if (m_buffer_TVALID && buffer_TREADY)
            mbq.push_back('{m_buffer_TDATA, m_buffer_TLAST, m_reorder_tag, m_core_sel});
        if (|(m_core_TVALID & core_TREADY))
            mcq.push_back('{m_core_TDATA, m_core_TLAST, m_reorder_tag, m_core_sel});
    end

    task automatic do_reset();
        rst = 1'b1;
        s_TVALID = 1'b0; s_TLAST = 1'b0; s_TDATA = '0;
        buffer_TREADY = 1'b1; core_TREADY = 4'hF; core_idle = 4'hF;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bq.delete(); cq.delete(); mbq.delete(); mcq.delete();
    endtask

    // Drive one packet of n beats (data base+i); acceptance judged just before the edge
    task automatic send_pkt(input int n, input logic [63:0] base, input bit rnd);
        int i = 0;
        int waits = 0;
        bit dead = 1'b0;
        while (i < n && !dead) begin
            @(negedge clk);
            s_TVALID = 1'b1;
            s_TDATA  = base + 64'(i);
            s_TLAST  = (i == n - 1);
            if (rnd) begin
                buffer_TREADY = 1'($urandom_range(0, 1));
                core_TREADY   = 4'($urandom_range(0, 15));
            end
            #1;
            if (s_TREADY) begin
                i++;
                waits = 0;
            end else begin
                waits++;
                if (waits > 300) begin
                    checks++; errors++;
                    $display("FAIL send_timeout: beat %0d of %0d never accepted", i, n);
                    dead = 1'b1;
                end
            end
        end
        @(negedge clk);
        s_TVALID = 1'b0; s_TLAST = 1'b0;
        buffer_TREADY = 1'b1; core_TREADY = 4'hF;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_TVALID = 1'b1; s_TLAST = 1'b0; s_TDATA = 64'hDEAD;
        buffer_TREADY = 1'b1; core_TREADY = 4'hF; core_idle = 4'hF;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({s_TREADY, buffer_TVALID, core_TVALID} !== 6'b0) begin
            errors++;
            $display("FAIL reset_valids: got %b want 000000", {s_TREADY, buffer_TVALID, core_TVALID});
        end
        checks++;
        if ({reorder_tag, core_sel} !== 8'b0) begin
            errors++;
            $display("FAIL reset_tag_sel: tag %0d sel %0d want 0 0", reorder_tag, core_sel);
        end
        do_reset();
    endtask

    task automatic test_basic();
        int lens[3] = '{4, 1, 7};
        int k = 0;
        do_reset();
        for (int p = 0; p < 3; p++) send_pkt(lens[p], 64'h100 * 64'(p + 1), 1'b0);
        checks++;
        if (bq.size() != 12 || cq.size() != 12) begin
            errors++;
            $display("FAIL basic_count: buf %0d core %0d want 12 12", bq.size(), cq.size());
        end else begin
            for (int p = 0; p < 3; p++) begin
                for (int b = 0; b < lens[p]; b++) begin
                    checks++;
                    if (bq[k].d !== 64'h100 * 64'(p + 1) + 64'(b) || bq[k].l !== (b == lens[p] - 1) ||
                        bq[k].t !== 6'(p) || cq[k].d !== bq[k].d || cq[k].l !== bq[k].l ||
                        cq[k].s !== 2'(p)) begin
                        errors++;
                        $display("FAIL basic_beat p%0d b%0d: buf d=%h l=%b t=%0d core d=%h l=%b s=%0d want d=%h l=%b t/s=%0d",
                                 p, b, bq[k].d, bq[k].l, bq[k].t, cq[k].d, cq[k].l, cq[k].s,
                                 64'h100 * 64'(p + 1) + 64'(b), (b == lens[p] - 1), p);
                    end
                    k++;
                end
            end
        end
    endtask

    task automatic test_tag_wrap();
        do_reset();
        for (int p = 0; p < 50; p++) send_pkt(1, 64'h1000 + 64'(p), 1'b0);
        checks++;
        if (bq.size() != 50) begin
            errors++;
            $display("FAIL wrap_count: got %0d want 50", bq.size());
        end else begin
            for (int p = 0; p < 50; p++) begin
                checks++;
                if (bq[p].t !== 6'(p) || bq[p].l !== 1'b1) begin
                    errors++;
                    $display("FAIL wrap_tag p%0d: got %0d want %0d", p, bq[p].t, p);
                end
            end
        end
        // 51st packet: circular buffer holds it off
        @(negedge clk);
        s_TVALID = 1'b1; s_TLAST = 1'b1; s_TDATA = 64'h1032; buffer_TREADY = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (s_TREADY !== 1'b0 || core_TVALID !== 4'b0 || reorder_tag !== 6'd0) begin
                errors++;
                $display("FAIL wrap_stall c%0d: tready %b cvalid %b tag %0d want 0 0000 0",
                         c, s_TREADY, core_TVALID, reorder_tag);
            end
            @(negedge clk);
        end
        buffer_TREADY = 1'b1;
        #1;
        checks++;
        if (s_TREADY !== 1'b1) begin
            errors++;
            $display("FAIL wrap_release: tready %b want 1", s_TREADY);
        end
        @(negedge clk);
        s_TVALID = 1'b0; s_TLAST = 1'b0;
        checks++;
        if (bq.size() != 51 || bq[bq.size()-1].t !== 6'd0 || bq[bq.size()-1].d !== 64'h1032) begin
            errors++;
            $display("FAIL wrap_51st: count %0d last tag %0d want 51 0", bq.size(),
                     (bq.size() > 0) ? bq[bq.size()-1].t : 6'h3F);
        end
    endtask

    task automatic test_core_select();
        do_reset();
        core_idle = 4'b0100;
        send_pkt(1, 64'h3000, 1'b0);
        checks++;
        if (cq.size() != 1 || cq[0].s !== 2'd2 || cq[0].d !== 64'h3000) begin
            errors++;
            $display("FAIL sel_idle2: count %0d sel %0d want 1 2", cq.size(),
                     (cq.size() > 0) ? cq[0].s : 2'd3);
        end
        core_idle = 4'b0000;
        @(negedge clk);
        s_TVALID = 1'b1; s_TLAST = 1'b1; s_TDATA = 64'h3001;
        for (int c = 0; c < 20; c++) begin
            #1;
            checks++;
            if (s_TREADY !== 1'b0 || core_TVALID !== 4'b0 || buffer_TVALID !== 1'b0) begin
                errors++;
                $display("FAIL no_idle c%0d: tready %b cvalid %b bvalid %b want 0", c,
                         s_TREADY, core_TVALID, buffer_TVALID);
            end
            @(negedge clk);
        end
        s_TVALID = 1'b0; s_TLAST = 1'b0;
        core_idle = 4'hF;
        checks++;
        if (bq.size() != 1) begin
            errors++;
            $display("FAIL no_idle_xfer: buf count %0d want 1", bq.size());
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        send_pkt(10, 64'h4000, 1'b1);
        checks++;
        if (bq.size() != 10 || cq.size() != 10) begin
            errors++;
            $display("FAIL bp_count: buf %0d core %0d want 10 10", bq.size(), cq.size());
        end else begin
            for (int b = 0; b < 10; b++) begin
                checks++;
                if (bq[b].d !== 64'h4000 + 64'(b) || cq[b].d !== 64'h4000 + 64'(b) ||
                    bq[b].l !== (b == 9) || cq[b].l !== (b == 9)) begin
                    errors++;
                    $display("FAIL bp_beat b%0d: buf %h/%b core %h/%b want %h/%b", b,
                             bq[b].d, bq[b].l, cq[b].d, cq[b].l, 64'h4000 + 64'(b), (b == 9));
                end
            end
        end
    endtask

    task automatic test_truncate();
        do_reset();
        send_pkt(12, 64'h5000, 1'b0);
        send_pkt(1, 64'h6000, 1'b0);
        checks++;
        if (mbq.size() != 9 || mcq.size() != 9) begin
            errors++;
            $display("FAIL trunc_count: buf %0d core %0d want 9 9", mbq.size(), mcq.size());
        end else begin
            for (int b = 0; b < 8; b++) begin
                checks++;
                if (mbq[b].d !== 64'h5000 + 64'(b) || mbq[b].l !== (b == 7) || mbq[b].t !== 6'd0 ||
                    mcq[b].d !== mbq[b].d || mcq[b].l !== mbq[b].l) begin
                    errors++;
                    $display("FAIL trunc_beat b%0d: d=%h l=%b t=%0d want d=%h l=%b t=0", b,
                             mbq[b].d, mbq[b].l, mbq[b].t, 64'h5000 + 64'(b), (b == 7));
                end
            end
            checks++;
            if (mbq[8].d !== 64'h6000 || mbq[8].t !== 6'd1 || mbq[8].l !== 1'b1 || mcq[8].s !== 2'd1) begin
                errors++;
                $display("FAIL trunc_next: d=%h t=%0d sel=%0d want 6000 1 1", mbq[8].d, mbq[8].t, mcq[8].s);
            end
        end
        checks++;
        if (bq.size() != 13 || bq[11].l !== 1'b1 || bq[7].l !== 1'b0) begin
            errors++;
            $display("FAIL full_len_count: got %0d want 13 beats", bq.size());
        end
    endtask

    task automatic test_reset_midpacket();
        int acc = 0;
        int waits = 0;
        do_reset();
        send_pkt(1, 64'h6F00, 1'b0);
        while (acc < 2 && waits < 50) begin
            @(negedge clk);
            s_TVALID = 1'b1; s_TLAST = 1'b0; s_TDATA = 64'h7000 + 64'(acc);
            #1;
            if (s_TREADY) acc++;
            waits++;
        end
        @(negedge clk);
        s_TDATA = 64'h7002;
        #1;
        checks++;
        if (buffer_TVALID !== 1'b1 || reorder_tag !== 6'd1 || core_sel !== 2'd1) begin
            errors++;
            $display("FAIL midpkt_pre: bvalid %b tag %0d sel %0d want 1 1 1", buffer_TVALID, reorder_tag, core_sel);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (buffer_TVALID !== 1'b0 || core_TVALID !== 4'b0 || s_TREADY !== 1'b0) begin
            errors++;
            $display("FAIL midpkt_rst: bvalid %b cvalid %b tready %b want 0", buffer_TVALID, core_TVALID, s_TREADY);
        end
        s_TVALID = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bq.delete(); cq.delete();
        send_pkt(2, 64'h8000, 1'b0);
        checks++;
        if (bq.size() != 2 || bq[0].t !== 6'd0 || cq.size() != 2 || cq[0].s !== 2'd0 || bq[1].l !== 1'b1) begin
            errors++;
            $display("FAIL midpkt_after: count %0d tag %0d sel %0d want 2 0 0", bq.size(),
                     (bq.size() > 0) ? bq[0].t : 6'h3F, (cq.size() > 0) ? cq[0].s : 2'd3);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tag_wrap();
        test_core_select();
        test_backpressure();
        test_truncate();
        test_reset_midpacket();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
